// File: rtl/muntjac_pkg.sv
// Shared fetch-redirect types: the reason tag seen by the fetcher and the
// redirect sequencer's state encoding.
package muntjac_pkg;

    typedef enum logic [2:0] {
        IF_PREFETCH      = 3'd0,
        IF_MISPREDICT    = 3'd1,
        IF_FENCE_I       = 3'd2,
        IF_SFENCE_VMA    = 3'd3,
        IF_SATP_CHANGED  = 3'd4,
        IF_PROT_CHANGED  = 3'd5
    } if_reason_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } redirect_state_e;

    function automatic logic reason_needs_flush(input if_reason_t r);
        return (r == IF_FENCE_I) || (r == IF_SFENCE_VMA) || (r == IF_SATP_CHANGED);
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl.sv
// Owns the fetcher PC override: arbitrates trap / system-op / mispredict
// redirects, sequences icache/ITLB flushes and tracks the fetch epoch.
//
// state    | meaning
// IDLE     | accepting system ops and mispredicts
// FLUSH    | flush request held to icache/TLB until flush_ack
// REDIRECT | one cycle; issue the latched system-op redirect
module fetch_redirect_ctrl
    import muntjac_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned EPOCH_W = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_pc,
    input  logic               sys_valid,
    input  if_reason_t         sys_reason,
    input  logic [XLEN-1:0]    sys_pc,
    output logic               sys_ready,
    input  logic               br_valid,
    input  logic [XLEN-1:0]    br_pc,
    input  logic [EPOCH_W-1:0] br_epoch,
    output logic               flush_valid,
    output logic               flush_icache,
    output logic               flush_tlb,
    input  logic               flush_ack,
    output logic [XLEN-1:0]    o_pc,
    output if_reason_t         o_reason,
    output logic               o_valid,
    output logic [EPOCH_W-1:0] o_epoch
);

    redirect_state_e state;
    logic            cancel;
    logic [XLEN-1:0] sys_pc_q;
    if_reason_t      sys_reason_q;

    logic            take_sys;
    logic            take_br;
    logic            pulse;
    logic [XLEN-1:0] pulse_pc;
    if_reason_t      pulse_reason;

    // A younger mispredict never survives alongside a serialising op, even
    // when that op is itself lost to a trap.
    always_comb begin
        take_sys     = sys_valid && (state == IDLE) && !trap_valid;
        take_br      = br_valid && !trap_valid && !sys_valid && (state == IDLE)
                       && (br_epoch == o_epoch);
        pulse        = 1'b0;
        pulse_pc     = '0;
        pulse_reason = IF_PREFETCH;
        if (trap_valid) begin
            pulse        = 1'b1;
            pulse_pc     = trap_pc;
            pulse_reason = IF_MISPREDICT;
        end else if (state == REDIRECT) begin
            pulse        = 1'b1;
            pulse_pc     = sys_pc_q;
            pulse_reason = sys_reason_q;
        end else if (take_br) begin
            pulse        = 1'b1;
            pulse_pc     = br_pc;
            pulse_reason = IF_MISPREDICT;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cancel       <= 1'b0;
            sys_pc_q     <= '0;
            sys_reason_q <= IF_PREFETCH;
            sys_ready    <= 1'b1;
            flush_valid  <= 1'b0;
            flush_icache <= 1'b0;
            flush_tlb    <= 1'b0;
            o_valid      <= 1'b0;
            o_pc         <= '0;
            o_reason     <= IF_PREFETCH;
            o_epoch      <= '0;
        end else begin
            o_valid <= pulse;
            if (pulse) begin
                o_pc     <= {pulse_pc[XLEN-1:1], 1'b0};
                o_reason <= pulse_reason;
                o_epoch  <= o_epoch + EPOCH_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (take_sys) begin
                        sys_pc_q     <= sys_pc;
                        sys_reason_q <= sys_reason;
                        cancel       <= 1'b0;
                        sys_ready    <= 1'b0;
                        if (reason_needs_flush(sys_reason)) begin
                            state        <= FLUSH;
                            flush_valid  <= 1'b1;
                            flush_icache <= (sys_reason == IF_FENCE_I);
                            flush_tlb    <= (sys_reason != IF_FENCE_I);
                        end else begin
                            state <= REDIRECT;
                        end
                    end
                end
                FLUSH: begin
                    if (trap_valid) cancel <= 1'b1;
                    if (flush_ack) begin
                        flush_valid  <= 1'b0;
                        flush_icache <= 1'b0;
                        flush_tlb    <= 1'b0;
                        // A trap taken during the flush already redirected fetch.
                        if (cancel || trap_valid) begin
                            state     <= IDLE;
                            sys_ready <= 1'b1;
                        end else begin
                            state <= REDIRECT;
                        end
                    end
                end
                REDIRECT: begin
                    state     <= IDLE;
                    sys_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    sys_ready <= 1'b1;
                end
            endcase
        end
    end

    a_ack_in_flush: assert property (@(posedge clk) disable iff (!resetn)
        flush_ack |-> (state == FLUSH));

    a_sys_reason: assert property (@(posedge clk) disable iff (!resetn)
        (sys_valid && sys_ready) |-> (sys_reason inside {IF_FENCE_I, IF_SFENCE_VMA,
                                                         IF_SATP_CHANGED, IF_PROT_CHANGED}));

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with hand-computed expectations.
module tb_fetch_redirect_ctrl;
    import muntjac_pkg::*;

    localparam int XLEN    = 64;
    localparam int EPOCH_W = 2;

    logic               clk = 1'b0;
    logic               resetn;
    logic               trap_valid;
    logic [XLEN-1:0]    trap_pc;
    logic               sys_valid;
    if_reason_t         sys_reason;
    logic [XLEN-1:0]    sys_pc;
    logic               sys_ready;
    logic               br_valid;
    logic [XLEN-1:0]    br_pc;
    logic [EPOCH_W-1:0] br_epoch;
    logic               flush_valid;
    logic               flush_icache;
    logic               flush_tlb;
    logic               flush_ack;
    logic [XLEN-1:0]    o_pc;
    if_reason_t         o_reason;
    logic               o_valid;
    logic [EPOCH_W-1:0] o_epoch;

    int total = 0;
    int bad   = 0;

    fetch_redirect_ctrl #(.XLEN(XLEN), .EPOCH_W(EPOCH_W)) dut (
        .clk(clk), .resetn(resetn),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .sys_valid(sys_valid), .sys_reason(sys_reason), .sys_pc(sys_pc),
        .sys_ready(sys_ready),
        .br_valid(br_valid), .br_pc(br_pc), .br_epoch(br_epoch),
        .flush_valid(flush_valid), .flush_icache(flush_icache), .flush_tlb(flush_tlb),
        .flush_ack(flush_ack),
        .o_pc(o_pc), .o_reason(o_reason), .o_valid(o_valid), .o_epoch(o_epoch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        trap_valid = 1'b0; trap_pc = '0;
        sys_valid = 1'b0; sys_reason = IF_PREFETCH; sys_pc = '0;
        br_valid = 1'b0; br_pc = '0; br_epoch = '0;
        flush_ack = 1'b0;
    endtask

    // Count pulses over n cycles, remembering the last one seen.
    task automatic watch(input int n, output int cnt, output logic [63:0] pc,
                         output logic [63:0] rsn);
        cnt = 0; pc = '0; rsn = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_valid) begin
                cnt++;
                pc  = o_pc;
                rsn = 64'(o_reason);
            end
        end
    endtask

    int          cnt;
    logic [63:0] wpc, wrsn;
    int          exp_epoch;

    initial begin
        clear_inputs();
        resetn = 1'b0;
        repeat (3) tick();
        chk("rst_flush_valid", 64'(flush_valid), 64'd0);
        resetn = 1'b1;

        chk("rst_o_pc", o_pc, 64'd0);
        chk("rst_o_reason", 64'(o_reason), 64'(IF_PREFETCH));
        chk("rst_flush_icache", 64'(flush_icache), 64'd0);
        chk("rst_flush_tlb", 64'(flush_tlb), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_o_valid", 64'(o_valid), 64'd0);
            chk("idle_o_epoch", 64'(o_epoch), 64'd0);
            chk("idle_sys_ready", 64'(sys_ready), 64'd1);
        end
        exp_epoch = 0;

        // mispredict with matching epoch; bit 0 cleared
        br_valid = 1'b1; br_pc = 64'h8000_1003; br_epoch = 2'd0;
        tick(); clear_inputs();
        exp_epoch = 1;
        chk("br_o_valid", 64'(o_valid), 64'd1);
        chk("br_o_pc", o_pc, 64'h8000_1002);
        chk("br_o_reason", 64'(o_reason), 64'(IF_MISPREDICT));
        chk("br_o_epoch", 64'(o_epoch), 64'(exp_epoch));
        tick();
        chk("br_pulse_width", 64'(o_valid), 64'd0);

        // stale epoch dropped
        br_valid = 1'b1; br_pc = 64'h8000_2000; br_epoch = 2'd0;
        tick(); clear_inputs();
        chk("stale_o_valid", 64'(o_valid), 64'd0);
        chk("stale_o_epoch", 64'(o_epoch), 64'(exp_epoch));

        // FENCE.I flush handshake
        sys_valid = 1'b1; sys_reason = IF_FENCE_I; sys_pc = 64'h100;
        tick(); clear_inputs();
        chk("fencei_flush_valid", 64'(flush_valid), 64'd1);
        chk("fencei_flush_icache", 64'(flush_icache), 64'd1);
        chk("fencei_flush_tlb", 64'(flush_tlb), 64'd0);
        chk("fencei_sys_ready", 64'(sys_ready), 64'd0);
        chk("fencei_no_early_pulse", 64'(o_valid), 64'd0);
        br_valid = 1'b1; br_pc = 64'h777; br_epoch = 2'(exp_epoch);
        repeat (3) tick();
        clear_inputs();
        chk("fencei_br_dropped", 64'(o_epoch), 64'(exp_epoch));
        chk("fencei_flush_held", 64'(flush_valid), 64'd1);
        flush_ack = 1'b1;
        tick(); clear_inputs();
        chk("fencei_flush_dropped", 64'(flush_valid), 64'd0);
        watch(3, cnt, wpc, wrsn);
        exp_epoch = 2;
        chk("fencei_pulse_count", 64'(cnt), 64'd1);
        chk("fencei_o_pc", wpc, 64'h100);
        chk("fencei_o_reason", wrsn, 64'(IF_FENCE_I));
        chk("fencei_o_epoch", 64'(o_epoch), 64'(exp_epoch));
        chk("fencei_sys_ready_back", 64'(sys_ready), 64'd1);

        // trap beats a same-cycle mispredict
        trap_valid = 1'b1; trap_pc = 64'h200;
        br_valid = 1'b1; br_pc = 64'h999; br_epoch = 2'(exp_epoch);
        tick(); clear_inputs();
        exp_epoch = 3;
        chk("trapbr_o_valid", 64'(o_valid), 64'd1);
        chk("trapbr_o_pc", o_pc, 64'h200);
        chk("trapbr_o_reason", 64'(o_reason), 64'(IF_MISPREDICT));
        chk("trapbr_o_epoch", 64'(o_epoch), 64'(exp_epoch));
        tick();
        chk("trapbr_single", 64'(o_valid), 64'd0);
        chk("trapbr_epoch_once", 64'(o_epoch), 64'(exp_epoch));

        // SFENCE.VMA cancelled by a trap mid-flush
        sys_valid = 1'b1; sys_reason = IF_SFENCE_VMA; sys_pc = 64'h400;
        tick(); clear_inputs();
        chk("sfence_flush_tlb", 64'(flush_tlb), 64'd1);
        chk("sfence_flush_icache", 64'(flush_icache), 64'd0);
        tick();
        trap_valid = 1'b1; trap_pc = 64'h300;
        tick(); clear_inputs();
        exp_epoch = 0;
        chk("sftrap_o_valid", 64'(o_valid), 64'd1);
        chk("sftrap_o_pc", o_pc, 64'h300);
        chk("sftrap_o_epoch", 64'(o_epoch), 64'(exp_epoch));
        chk("sftrap_flush_held", 64'(flush_valid), 64'd1);
        tick(); tick();
        chk("sftrap_tlb_held", 64'(flush_tlb), 64'd1);
        flush_ack = 1'b1;
        tick(); clear_inputs();
        chk("sftrap_flush_done", 64'(flush_valid), 64'd0);
        watch(3, cnt, wpc, wrsn);
        chk("sftrap_no_second", 64'(cnt), 64'd0);
        chk("sftrap_sys_ready", 64'(sys_ready), 64'd1);
        chk("sftrap_epoch", 64'(o_epoch), 64'(exp_epoch));

        // four back-to-back mispredicts: epoch 1,2,3,0
        for (int i = 0; i < 4; i++) begin
            br_valid = 1'b1; br_pc = 64'h1000 + 64'(i * 16); br_epoch = 2'(i);
            tick();
            chk("wrap_o_valid", 64'(o_valid), 64'd1);
            chk("wrap_o_epoch", 64'(o_epoch), 64'((i + 1) % 4));
            chk("wrap_o_pc", o_pc, 64'h1000 + 64'(i * 16));
        end
        clear_inputs();
        exp_epoch = 0;

        // privilege change: no flush; same-cycle mispredict dropped
        sys_valid = 1'b1; sys_reason = IF_PROT_CHANGED; sys_pc = 64'h501;
        br_valid = 1'b1; br_pc = 64'h888; br_epoch = 2'(exp_epoch);
        tick(); clear_inputs();
        chk("prot_no_flush", 64'(flush_valid), 64'd0);
        chk("prot_sys_ready", 64'(sys_ready), 64'd0);
        chk("prot_br_dropped", 64'(o_valid), 64'd0);
        watch(2, cnt, wpc, wrsn);
        exp_epoch = 1;
        chk("prot_pulse_count", 64'(cnt), 64'd1);
        chk("prot_o_pc", wpc, 64'h500);
        chk("prot_o_reason", wrsn, 64'(IF_PROT_CHANGED));
        chk("prot_o_epoch", 64'(o_epoch), 64'(exp_epoch));

        // trap and sys in the same cycle: sys not accepted
        trap_valid = 1'b1; trap_pc = 64'h600;
        sys_valid = 1'b1; sys_reason = IF_FENCE_I; sys_pc = 64'h700;
        tick(); clear_inputs();
        exp_epoch = 2;
        chk("trapsys_o_pc", o_pc, 64'h600);
        chk("trapsys_no_flush", 64'(flush_valid), 64'd0);
        watch(3, cnt, wpc, wrsn);
        chk("trapsys_no_sys_pulse", 64'(cnt), 64'd0);
        chk("trapsys_epoch", 64'(o_epoch), 64'(exp_epoch));

        // reset mid-flush drops flush_valid asynchronously
        sys_valid = 1'b1; sys_reason = IF_SATP_CHANGED; sys_pc = 64'h900;
        tick(); clear_inputs();
        chk("satp_flush_tlb", 64'(flush_tlb), 64'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_flush", 64'(flush_valid), 64'd0);
        chk("async_rst_epoch", 64'(o_epoch), 64'd0);
        chk("async_rst_ready", 64'(sys_ready), 64'd1);
        tick();
        resetn = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
